// File: rtl/ft_host_pkg.sv
// Shared definitions for the FT245 host-side blocks: word width, default
// requester count and the out-arbiter state encoding.
package ft_host_pkg;

    localparam int FT_WORD_W          = 32;
    localparam int FT_NUM_REQ_DEFAULT = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_XFER  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ft_out_arbiter_if.sv
// Requester side plus out-FIFO write side of the out arbiter.
// Handshake: a requester word moves when req_valid[i] & req_ready[i] are both
// high at a rising clk edge; once valid is raised, data/last stay stable until
// that edge. out_fifo_wr is a one-cycle write strobe that is never high while
// out_fifo_full is high.
interface ft_out_arbiter_if
    import ft_host_pkg::*;
#(
    parameter int NUM_REQ = FT_NUM_REQ_DEFAULT
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [FT_WORD_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         out_fifo_wr;
    logic [FT_WORD_W-1:0]         out_fifo_data;
    logic                         out_fifo_full;

    // Arbiter side
    modport master (
        input  req_valid, req_last, req_data, out_fifo_full,
        output req_ready, out_fifo_wr, out_fifo_data
    );

    // Requesters plus FIFO side
    modport slave (
        output req_valid, req_last, req_data, out_fifo_full,
        input  req_ready, out_fifo_wr, out_fifo_data
    );
endinterface

// File: rtl/ft_out_arbiter_rr_priority_pick.sv
// Combinational rotating-priority selector: the search starts one past the
// previous grant and wraps, so the most recent winner has lowest priority.
module rr_priority_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_grant,
    output logic [2:0]         winner,
    output logic               found
);

    logic [3:0] cand;

    // Walk the candidates in rotated order and keep the first requesting one
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + 4'd1 + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (cand == 4'(j)) && req[j]) begin
                    winner = 3'(j);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ft_out_arbiter.sv
// Packet-level round-robin arbiter in front of the out FIFO write port.
// A granted packet runs to its last word (or to MAX_WORDS) before any other
// requester is considered, so packets never interleave on the USB stream.
module ft_out_arbiter
    import ft_host_pkg::*;
#(
    parameter int NUM_REQ   = FT_NUM_REQ_DEFAULT,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    ft_out_arbiter_if.master  bus,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              len_err,
    output logic [1:0]        dbg_state
);

    localparam int              CNT_W   = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_GRANT = ARB_GRANT;
    localparam logic [1:0] S_XFER  = ARB_XFER;

    logic [1:0]           state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 len_err_q, len_err_d;

    logic [2:0]           pick_idx;
    logic                 pick_found;
    logic                 in_xfer;
    logic                 sel_valid;
    logic                 sel_last;
    logic [FT_WORD_W-1:0] sel_data;
    logic [NUM_REQ-1:0]   ready_v;
    logic                 xfer_fire;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (grant_q),
        .winner     (pick_idx),
        .found      (pick_found)
    );

    // Route the granted requester's valid/last/data and build its ready bit
    always_comb begin
        in_xfer   = (state_q == S_XFER);
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ready_v   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_valid  = bus.req_valid[i];
                sel_last   = bus.req_last[i];
                sel_data   = bus.req_data[FT_WORD_W*i +: FT_WORD_W];
                ready_v[i] = in_xfer && !bus.out_fifo_full;
            end
        end
        xfer_fire = in_xfer && !bus.out_fifo_full && sel_valid;
    end

    assign bus.req_ready     = ready_v;
    assign bus.out_fifo_wr   = xfer_fire;
    assign bus.out_fifo_data = in_xfer ? sel_data : '0;

    assign busy      = (state_q == S_GRANT) || (state_q == S_XFER);
    assign grant_id  = grant_q;
    assign len_err   = len_err_q;
    assign dbg_state = state_q;

    // FSM, winner capture, word counter and length guard
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_GRANT;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                state_d = S_XFER;
            end
            S_XFER: begin
                if (xfer_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_last) begin
                        state_d = S_IDLE;
                    end else if ((cnt_q + 1'b1) == MAX_CNT) begin
                        // Runaway packet: release the port, the rest re-arbitrates
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; grant resets to the top index so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 3'(NUM_REQ - 1);
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_ft_out_arbiter.sv
// Bench for ft_out_arbiter with NUM_REQ=2 and MAX_WORDS=4.
module tb_ft_out_arbiter;
    import ft_host_pkg::*;

    localparam int NREQ = 2;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [2:0] grant_id;
    logic       len_err;
    logic [1:0] dbg_state;

    ft_out_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    ft_out_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .grant_id  (grant_id),
        .len_err   (len_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [32:0] src0_q[$];
    logic [32:0] src1_q[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          wr_count = 0;
    int          busy_cnt = 0;
    bit          fire0 = 0;
    bit          fire1 = 0;
    bit          hold0 = 0;
    int          last_grant_m = NREQ - 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Rotating-priority reference: first requester at or after last+1
    function automatic int rr_model(input int last, input logic [NREQ-1:0] req);
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return last;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_word(input int r, input logic [31:0] d, input logic l);
        if (r == 0) src0_q.push_back({l, d});
        else        src1_q.push_back({l, d});
    endtask

    task automatic push_pkt(input int r, input logic [31:0] base, input int n,
                            input bit with_last, input bit add_exp);
        for (int i = 1; i <= n; i++) begin
            push_word(r, base + 32'(i), (with_last && i == n) ? 1'b1 : 1'b0);
            if (add_exp) exp_q.push_back(base + 32'(i));
        end
    endtask

    // Present queue heads; retire a word after the edge that accepted it
    initial begin
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.req_data      = '0;
        bus.out_fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (fire0 && src0_q.size() != 0) void'(src0_q.pop_front());
            if (fire1 && src1_q.size() != 0) void'(src1_q.pop_front());
            fire0 = 0;
            fire1 = 0;
            bus.req_valid[0] = (src0_q.size() != 0) && !hold0;
            bus.req_last[0]  = (src0_q.size() != 0) ? src0_q[0][32] : 1'b0;
            bus.req_data[31:0] = (src0_q.size() != 0) ? src0_q[0][31:0] : 32'h0;
            bus.req_valid[1] = (src1_q.size() != 0);
            bus.req_last[1]  = (src1_q.size() != 0) ? src1_q[0][32] : 1'b0;
            bus.req_data[63:32] = (src1_q.size() != 0) ? src1_q[0][31:0] : 32'h0;
        end
    end

    // Monitor: handshakes, write ordering, protocol rules
    always @(negedge clk) begin
        if (!rst) begin
            fire0 = bus.req_valid[0] && bus.req_ready[0];
            fire1 = bus.req_valid[1] && bus.req_ready[1];
            if (busy) busy_cnt++;
            check_eq("wr_eq_fire", 32'(bus.out_fifo_wr), 32'(fire0 | fire1));
            check_eq("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            if (bus.out_fifo_full) check_eq("wr_while_full", 32'(bus.out_fifo_wr), 32'd0);
            if (bus.out_fifo_wr) begin
                wr_count++;
                check_eq("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("wdata", bus.out_fifo_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!(src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 && !busy) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("done_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_count < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("writes_timeout", 32'(wr_count >= target), 32'd1);
    endtask

    // Both requesters raise valid together; model decides the order
    task automatic run_both();
        int first, second;
        first  = rr_model(last_grant_m, 2'b11);
        second = 1 - first;
        @(negedge clk);
        push_pkt(0, 32'h0000_0000, 2, 1, 0);
        push_pkt(1, 32'hAAAA_0000, 2, 1, 0);
        for (int p = 0; p < 2; p++) begin
            int r = (p == 0) ? first : second;
            for (int i = 1; i <= 2; i++)
                exp_q.push_back(((r == 0) ? 32'h0000_0000 : 32'hAAAA_0000) + 32'(i));
        end
        last_grant_m = second;
        wait_done();
        check_eq("both_grant_id", 32'(grant_id), 32'(last_grant_m));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int lat;
        int n;
        rst = 1'b1;
        #3;
        check_eq("rst_wr", 32'(bus.out_fifo_wr), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_data", bus.out_fifo_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'(NREQ - 1));
        check_eq("rst_len_err", 32'(len_err), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests just after reset: requester 0 first
        run_both();

        // Single 4-word packet: latency, busy span, order
        base = wr_count;
        @(negedge clk);
        #1;
        busy_cnt = 0;
        push_pkt(0, 32'h0000_0000, 0, 1, 0);
        src0_q.push_back({1'b0, 32'h1111_1111});
        src0_q.push_back({1'b0, 32'h2222_2222});
        src0_q.push_back({1'b0, 32'h3333_3333});
        src0_q.push_back({1'b1, 32'h4444_4444});
        exp_q.push_back(32'h1111_1111);
        exp_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h3333_3333);
        exp_q.push_back(32'h4444_4444);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_valid[0] && n < 10);
        lat = 0;
        while (!bus.out_fifo_wr && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t1_latency", 32'(lat), 32'd2);
        last_grant_m = 0;
        wait_done();
        check_eq("t1_writes", 32'(wr_count - base), 32'd4);
        check_eq("t1_busy_cycles", 32'(busy_cnt), 32'd5);

        // Simultaneous requests again, now after a requester-0 grant
        run_both();

        // Full held for 3 cycles mid-packet
        base = wr_count;
        @(negedge clk);
        push_pkt(0, 32'h3000_0000, 4, 1, 1);
        wait_writes(base + 2);
        @(posedge clk);
        #2;
        bus.out_fifo_full = 1'b1;
        repeat (3) begin
            #2;
            check_eq("t3_ready_full", 32'(bus.req_ready), 32'd0);
            check_eq("t3_wr_full", 32'(bus.out_fifo_wr), 32'd0);
            @(posedge clk);
            #2;
        end
        bus.out_fifo_full = 1'b0;
        #2;
        check_eq("t3_resume", 32'(bus.out_fifo_wr), 32'd1);
        last_grant_m = 0;
        wait_done();
        check_eq("t3_writes", 32'(wr_count - base), 32'd4);

        // Runaway packet: 4 words without last trip the length guard
        check_eq("t4_len_err_pre", 32'(len_err), 32'd0);
        base = wr_count;
        @(negedge clk);
        push_pkt(0, 32'h4000_0000, 8, 1, 1);
        wait_writes(base + 4);
        @(posedge clk);
        #3;
        check_eq("t4_len_err", 32'(len_err), 32'd1);
        check_eq("t4_idle", 32'(dbg_state), 32'(ARB_IDLE));
        check_eq("t4_idle_wr", 32'(bus.out_fifo_wr), 32'd0);
        @(posedge clk);
        #3;
        check_eq("t4_grant", 32'(dbg_state), 32'(ARB_GRANT));
        check_eq("t4_grant_wr", 32'(bus.out_fifo_wr), 32'd0);
        @(posedge clk);
        #3;
        check_eq("t4_rewrite", 32'(bus.out_fifo_wr), 32'd1);
        check_eq("t4_rewrite_data", bus.out_fifo_data, 32'h4000_0005);
        wait_done();
        check_eq("t4_writes", 32'(wr_count - base), 32'd8);
        check_eq("t4_len_err_sticky", 32'(len_err), 32'd1);

        // Asynchronous reset after the second word
        base = wr_count;
        @(negedge clk);
        push_pkt(0, 32'h5000_0000, 4, 1, 1);
        wait_writes(base + 2);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_wr", 32'(bus.out_fifo_wr), 32'd0);
        check_eq("t5_ready", 32'(bus.req_ready), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_data", bus.out_fifo_data, 32'd0);
        check_eq("t5_grant", 32'(grant_id), 32'(NREQ - 1));
        check_eq("t5_len_err", 32'(len_err), 32'd0);
        check_eq("t5_state", 32'(dbg_state), 32'(ARB_IDLE));
        src0_q.delete();
        exp_q.delete();
        fire0 = 0;
        fire1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_grant_m = NREQ - 1;
        repeat (8) @(negedge clk);
        #1;
        check_eq("t5_no_resume", 32'(wr_count - base), 32'd2);
        check_eq("t5_idle_busy", 32'(busy), 32'd0);

        // Valid gap mid-packet while requester 1 waits
        base = wr_count;
        @(negedge clk);
        push_pkt(0, 32'h6000_0000, 4, 1, 0);
        push_pkt(1, 32'h6100_0000, 2, 1, 0);
        if (rr_model(last_grant_m, 2'b11) == 0) begin
            for (int i = 1; i <= 4; i++) exp_q.push_back(32'h6000_0000 + 32'(i));
            for (int i = 1; i <= 2; i++) exp_q.push_back(32'h6100_0000 + 32'(i));
            last_grant_m = 1;
        end else begin
            for (int i = 1; i <= 2; i++) exp_q.push_back(32'h6100_0000 + 32'(i));
            for (int i = 1; i <= 4; i++) exp_q.push_back(32'h6000_0000 + 32'(i));
            last_grant_m = 0;
        end
        wait_writes(base + 2);
        hold0 = 1;
        repeat (10) begin
            @(posedge clk);
            #3;
            check_eq("t6_no_ready1", 32'(bus.req_ready[1]), 32'd0);
            check_eq("t6_no_wr", 32'(bus.out_fifo_wr), 32'd0);
            check_eq("t6_grant_held", 32'(grant_id), 32'd0);
            check_eq("t6_busy", 32'(busy), 32'd1);
        end
        hold0 = 0;
        wait_done();
        check_eq("t6_writes", 32'(wr_count - base), 32'd6);
        check_eq("t6_grant_end", 32'(grant_id), 32'(last_grant_m));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
